// File: rtl/router_pkt_source.sv
// router_pkt_source: upstream packet formatter for the 1x3 router ingress.
// Takes a (dest, len) command and len payload bytes, buffers the whole payload,
// then emits header, payload (pkt_valid=1) and parity (pkt_valid=0) as one
// unbroken burst so payload-side stalls never look like a parity cycle.
// Optional build macro PKT_SRC_PARITY_INJECT_EN adds corrupt_par, which makes
// the parity cycle carry the inverted parity for that packet.
module router_pkt_source #(
   parameter int LEN_W    = 6,
   parameter int IDLE_GAP = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_dest,
   input  logic [LEN_W-1:0] cmd_len,
`ifdef PKT_SRC_PARITY_INJECT_EN
   input  logic             corrupt_par,
`endif
   input  logic             pl_valid,
   output logic             pl_ready,
   input  logic [7:0]       pl_data,
   input  logic             busy,
   output logic             pkt_valid,
   output logic [7:0]       pkt_data,
   output logic             pkt_done,
   output logic             src_busy
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_HDR  = 3'd3;
   localparam logic [2:0] S_PAY  = 3'd4;
   localparam logic [2:0] S_PAR  = 3'd5;
   localparam logic [2:0] S_GAP  = 3'd6;
   localparam int DEPTH = 2**LEN_W;
   localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

   logic [2:0]       state;
   logic [1:0]       dest_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] wr_ptr;
   logic [LEN_W-1:0] rd_ptr;
   logic [7:0]       par_q;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]       mem [DEPTH];
   logic [7:0]       hdr;
   logic [7:0]       par_out;
   logic             cmd_acc;
   logic             pl_acc;

   // Header byte is {len,dest}; the router format assumes LEN_W+2 == 8.
   assign hdr     = 8'({len_q, dest_q});
   assign cmd_acc = cmd_valid && cmd_ready;
   assign pl_acc  = pl_valid && pl_ready;

`ifdef PKT_SRC_PARITY_INJECT_EN
   logic corrupt_q;
   // Corruption request is captured with the command and applied only on the parity byte.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)        corrupt_q <= 1'b0;
      else if (cmd_acc) corrupt_q <= corrupt_par;
   end
   assign par_out = par_q ^ {8{corrupt_q}};
`else
   assign par_out = par_q;
`endif

   // Payload buffer; pointers restart at 0 every packet so no wrap handling is needed.
   always_ff @(posedge clock) begin
      if (pl_acc) mem[wr_ptr] <= pl_data;
   end

   // Packet FSM; every output is registered alongside the state it belongs to.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         dest_q    <= '0;
         len_q     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         par_q     <= '0;
         gap_cnt   <= '0;
         cmd_ready <= 1'b0;
         pl_ready  <= 1'b0;
         pkt_valid <= 1'b0;
         pkt_data  <= 8'h00;
         pkt_done  <= 1'b0;
         src_busy  <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_acc) begin
                  dest_q    <= cmd_dest;
                  len_q     <= cmd_len;
                  par_q     <= 8'({cmd_len, cmd_dest});
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  cmd_ready <= 1'b0;
                  src_busy  <= 1'b1;
                  if (cmd_len != '0) begin
                     state    <= S_LOAD;
                     pl_ready <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            S_LOAD: begin
               if (pl_acc) begin
                  wr_ptr <= wr_ptr + LEN_W'(1);
                  par_q  <= par_q ^ pl_data;
                  if (wr_ptr == len_q - LEN_W'(1)) begin
                     pl_ready <= 1'b0;
                     state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (!busy) begin
                  state     <= S_HDR;
                  pkt_valid <= 1'b1;
                  pkt_data  <= hdr;
               end
            end
            S_HDR, S_PAY: begin
               // rd_ptr counts payload bytes already placed on the bus.
               if (rd_ptr == len_q) begin
                  state     <= S_PAR;
                  pkt_valid <= 1'b0;
                  pkt_data  <= par_out;
                  pkt_done  <= 1'b1;
               end else begin
                  state    <= S_PAY;
                  pkt_data <= mem[rd_ptr];
                  rd_ptr   <= rd_ptr + LEN_W'(1);
               end
            end
            S_PAR: begin
               pkt_data <= 8'h00;
               if (IDLE_GAP != 0) begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
               end else begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  src_busy  <= 1'b0;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  src_busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state     <= S_IDLE;
               pl_ready  <= 1'b0;
               pkt_valid <= 1'b0;
               pkt_data  <= 8'h00;
               src_busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_router_pkt_source.sv
// tb_router_pkt_source: directed table, busy/back-to-back/abort sequences and
// randomized packets checked against a packet-level reference model.
module tb_router_pkt_source;
   localparam int GAP = 2;

   logic       clock, reset;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_dest;
   logic [5:0] cmd_len;
   logic       pl_valid, pl_ready;
   logic [7:0] pl_data;
   logic       busy;
   logic       pkt_valid, pkt_done, src_busy;
   logic [7:0] pkt_data;
`ifdef PKT_SRC_PARITY_INJECT_EN
   logic       corrupt_par;
`endif

   router_pkt_source #(.LEN_W(6), .IDLE_GAP(GAP)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
`ifdef PKT_SRC_PARITY_INJECT_EN
      .corrupt_par(corrupt_par),
`endif
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
      .busy(busy),
      .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_done(pkt_done), .src_busy(src_busy)
   );

   typedef struct packed {
      logic [1:0]  dest;
      logic [5:0]  len;
      logic [31:0] pl;    // byte i at [8*i +: 8]
      logic [1:0]  gapn;  // idle cycles between payload bytes
      logic [7:0]  hdr;
      logic [7:0]  par;
   } vec_t;

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   logic [7:0] tx_pl [64];
   logic [7:0] mon_b[$], mon_p[$], exp_b[$], exp_p[$];
   int mon_n[$], exp_n[$], hdr_q[$], parc_q[$];
   int last_p = -1;
   int last_l = 0;
   int cur_n = 0;
   bit prev_v = 0, pl_seen = 0, rnd_busy = 0;

   initial begin clock = 0; forever #5 clock = ~clock; end
   initial forever begin @(posedge clock); cyc++; end
   initial begin #500000; $display("FAIL watchdog: time limit reached"); $fatal(1); end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Packet monitor and per-cycle protocol rules.
   initial forever begin
      @(negedge clock);
      if (reset) begin
         prev_v = 0; cur_n = 0;
      end else begin
         chk("rdy_excl", {31'd0, cmd_ready & pl_ready}, 0);
         chk("done_at_par", {31'd0, pkt_done}, {31'd0, prev_v & ~pkt_valid});
         if (!pkt_valid && !pkt_done) chk("idle_data", {24'd0, pkt_data}, 0);
         if (pl_ready) pl_seen = 1;
         if (pkt_valid) begin
            if (!prev_v) hdr_q.push_back(cyc);
            mon_b.push_back(pkt_data);
            cur_n++;
         end else if (prev_v) begin
            mon_p.push_back(pkt_data);
            mon_n.push_back(cur_n);
            parc_q.push_back(cyc);
            cur_n = 0;
         end
         prev_v = pkt_valid;
      end
   end

   initial forever begin
      @(negedge clock);
      if (rnd_busy) busy = ($urandom_range(0, 3) == 0);
   end

   task automatic exp_push(input logic [7:0] h, input int n, input logic [7:0] par);
      exp_b.push_back(h);
      for (int i = 0; i < n; i++) exp_b.push_back(tx_pl[i]);
      exp_n.push_back(n);
      exp_p.push_back(par);
   endtask

   // Reference: header {len,dest}; parity is the XOR of header and every payload byte.
   task automatic model_push(input logic [1:0] d, input int l, input bit cor);
      logic [7:0] h, par;
      h = {l[5:0], d};
      par = h;
      for (int i = 0; i < l; i++) par = par ^ tx_pl[i];
      if (cor) par = ~par;
      exp_push(h, l, par);
   endtask

   task automatic send_cmd(input logic [1:0] d, input int l, output int c);
      int n = 0;
      cmd_dest = d; cmd_len = l[5:0]; cmd_valid = 1;
      while (!cmd_ready && n < 3000) begin @(negedge clock); n++; end
      c = cyc;
      if (!cmd_ready) chk("cmd_timeout", 0, 1);
      @(negedge clock);
      cmd_valid = 0;
   endtask

   // mode < 0: random idle cycles between bytes; otherwise a fixed count.
   task automatic send_pl(input int n, input int mode);
      int k, t;
      for (int i = 0; i < n; i++) begin
         k = (mode < 0) ? (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0) : mode;
         if (i > 0 && k > 0) begin pl_valid = 0; repeat (k) @(negedge clock); end
         pl_valid = 1; pl_data = tx_pl[i];
         t = 0;
         while (!pl_ready && t < 3000) begin @(negedge clock); t++; end
         if (!pl_ready) chk("pl_timeout", 0, 1);
         last_l = cyc;
         @(negedge clock);
      end
      pl_valid = 0;
   endtask

   task automatic verify(input string nm, output int h, output int p);
      int n = 0, en, mn;
      logic [7:0] b;
      h = 0; p = 0;
      while (mon_p.size() == 0 && n < 5000) begin @(negedge clock); n++; end
      if (mon_p.size() == 0 || exp_n.size() == 0) begin chk({nm, "_timeout"}, 0, 1); return; end
      en = exp_n.pop_front();
      mn = mon_n.pop_front();
      chk({nm, "_burst_len"}, mn, en + 1);
      for (int i = 0; i < mn; i++) begin
         b = mon_b.pop_front();
         if (i <= en) chk($sformatf("%s_b%0d", nm, i), {24'd0, b}, {24'd0, exp_b[i]});
      end
      for (int i = 0; i <= en; i++) void'(exp_b.pop_front());
      chk({nm, "_parity"}, {24'd0, mon_p.pop_front()}, {24'd0, exp_p.pop_front()});
      h = hdr_q.pop_front();
      p = parc_q.pop_front();
      if (last_p >= 0) chk({nm, "_idle_gap_ok"}, {31'd0, (h - last_p - 1) >= GAP + 2}, 1);
      last_p = p;
   endtask

   task automatic flush();
      mon_b.delete(); mon_p.delete(); mon_n.delete(); hdr_q.delete(); parc_q.delete();
      exp_b.delete(); exp_p.delete(); exp_n.delete();
      last_p = -1;
   endtask

   vec_t vt [5];
   int c, h, p, b, n, ln;

   initial begin
      vt[0] = '{dest:2'd1, len:6'd3, pl:32'h00332211, gapn:2'd0, hdr:8'h0D, par:8'h0D};
      vt[1] = '{dest:2'd2, len:6'd0, pl:32'h00000000, gapn:2'd0, hdr:8'h02, par:8'h02};
      vt[2] = '{dest:2'd3, len:6'd1, pl:32'h000000FF, gapn:2'd0, hdr:8'h07, par:8'hF8};
      vt[3] = '{dest:2'd0, len:6'd4, pl:32'h08040201, gapn:2'd2, hdr:8'h10, par:8'h1F};
      vt[4] = '{dest:2'd3, len:6'd2, pl:32'h00005AA5, gapn:2'd0, hdr:8'h0B, par:8'hF4};

      reset = 0; cmd_valid = 0; cmd_dest = 0; cmd_len = 0;
      pl_valid = 0; pl_data = 0; busy = 0;
`ifdef PKT_SRC_PARITY_INJECT_EN
      corrupt_par = 0;
`endif
      #1 reset = 1;
      #1;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
      chk("rst_pl_ready",  {31'd0, pl_ready}, 0);
      chk("rst_pkt_valid", {31'd0, pkt_valid}, 0);
      chk("rst_pkt_data",  {24'd0, pkt_data}, 0);
      chk("rst_pkt_done",  {31'd0, pkt_done}, 0);
      chk("rst_src_busy",  {31'd0, src_busy}, 0);
      repeat (2) @(negedge clock);
      reset = 0;
      @(negedge clock);
      chk("cmd_ready_up", {31'd0, cmd_ready}, 1);

      // Directed table
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) tx_pl[i] = vt[k].pl[8*i +: 8];
         exp_push(vt[k].hdr, int'(vt[k].len), vt[k].par);
         pl_seen = 0;
         send_cmd(vt[k].dest, int'(vt[k].len), c);
         chk($sformatf("vec%0d_cmd_ready_low", k), {31'd0, cmd_ready}, 0);
         chk($sformatf("vec%0d_src_busy", k), {31'd0, src_busy}, 1);
         chk($sformatf("vec%0d_pl_ready", k), {31'd0, pl_ready}, {31'd0, vt[k].len != 0});
         if (vt[k].len != 0) send_pl(int'(vt[k].len), int'(vt[k].gapn));
         else last_l = c;
         verify($sformatf("vec%0d", k), h, p);
         chk($sformatf("vec%0d_hdr_lat", k), h, last_l + 2);
         chk($sformatf("vec%0d_par_lat", k), p, h + 1 + int'(vt[k].len));
         if (vt[k].len == 0) chk($sformatf("vec%0d_no_pl_ready", k), {31'd0, pl_seen}, 0);
      end

      // Busy held after the load completes
      tx_pl[0] = 8'h5C; tx_pl[1] = 8'hC5;
      exp_push(8'h0A, 2, 8'h93);
      busy = 1;
      send_cmd(2'd2, 2, c);
      send_pl(2, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk($sformatf("busy_hold%0d", i), {31'd0, pkt_valid}, 0);
      end
      chk("busy_src_busy", {31'd0, src_busy}, 1);
      busy = 0; b = cyc;
      verify("busy", h, p);
      chk("busy_hdr_lat", h, b + 1);

      // len=63 ramp followed immediately by a second command
      for (int i = 0; i < 63; i++) tx_pl[i] = 8'(i);
      model_push(2'd1, 63, 0);
      send_cmd(2'd1, 63, c);
      send_pl(63, 0);
      for (int i = 0; i < 5; i++) tx_pl[i] = 8'($urandom);
      model_push(2'd0, 5, 0);
      send_cmd(2'd0, 5, c);
      send_pl(5, 0);
      verify("ramp63", h, p);
      verify("b2b", h, p);

      // Reset in the middle of the payload burst
      for (int i = 0; i < 8; i++) tx_pl[i] = 8'($urandom);
      send_cmd(2'd3, 8, c);
      send_pl(8, 0);
      n = 0;
      while (!pkt_valid && n < 100) begin @(negedge clock); n++; end
      chk("abort_started", {31'd0, pkt_valid}, 1);
      repeat (3) @(negedge clock);
      reset = 1;
      #1;
      chk("abort_pkt_valid", {31'd0, pkt_valid}, 0);
      chk("abort_src_busy", {31'd0, src_busy}, 0);
      chk("abort_pkt_done", {31'd0, pkt_done}, 0);
      repeat (2) @(negedge clock);
      reset = 0;
      @(posedge clock);
      flush();
      @(negedge clock);
      chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
      for (int i = 0; i < 6; i++) tx_pl[i] = 8'($urandom);
      model_push(2'd2, 6, 0);
      send_cmd(2'd2, 6, c);
      send_pl(6, 0);
      verify("post_abort", h, p);

`ifdef PKT_SRC_PARITY_INJECT_EN
      for (int i = 0; i < 3; i++) tx_pl[i] = 8'($urandom);
      model_push(2'd1, 3, 1);
      corrupt_par = 1;
      send_cmd(2'd1, 3, c);
      corrupt_par = 0;
      send_pl(3, 0);
      verify("corrupt", h, p);
      model_push(2'd1, 3, 0);
      send_cmd(2'd1, 3, c);
      send_pl(3, 0);
      verify("uncorrupt", h, p);
`endif

      // Randomized batches with random busy and payload stalls
      rnd_busy = 1;
      for (int bt = 0; bt < 3; bt++) begin
         for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, 9);
            ln = (n == 0) ? 0 : (n == 1) ? 63 : $urandom_range(1, 20);
            for (int i = 0; i < ln; i++) tx_pl[i] = 8'($urandom);
            b = $urandom_range(0, 3);
            model_push(b[1:0], ln, 0);
            // Offer the first byte early; it must not be taken before LOAD.
            if (ln > 0 && $urandom_range(0, 1) == 1) begin pl_valid = 1; pl_data = tx_pl[0]; end
            send_cmd(b[1:0], ln, c);
            if (ln > 0) send_pl(ln, -1);
            else pl_valid = 0;
         end
         for (int k = 0; k < 8; k++) verify($sformatf("rnd%0d_%0d", bt, k), h, p);
      end
      rnd_busy = 0;
      busy = 0;
      repeat (4) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
